dmem_lsu: RTL and testbench

- Memory-stage load/store unit between the pipeline's M stage and a single-port data-memory bus with request/grant and response-valid handshakes.
- Converts aluoutM/writedataM plus width controls into a word-aligned bus access with byte strobes.
- Stalls the pipeline until the access completes, then returns the load data sign- or zero-extended.
- Detects misaligned accesses and times out unresponsive loads.

---
 rtl/dmem_lsu.sv | 189 ++++++++++++++++++
 tb/tb_dmem_lsu.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_lsu.sv
// dmem_lsu: M-stage load/store unit for a request/grant data bus.
// Aligns, strobes and extends accesses; flags misalign and load timeouts.
module dmem_lsu #(
  parameter int XLEN      = 32,
  parameter int ADDR_SIZE = 32,
  parameter int TIMEOUT   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 memreqM,
  input  logic                 memwriteM,
  input  logic [ADDR_SIZE-1:0] addrM,
  input  logic [XLEN-1:0]      writedataM,
  input  logic [1:0]           whbM,
  input  logic                 lunsignedM,
  output logic [XLEN-1:0]      readdataM,
  output logic                 done_o,
  output logic                 stallM,
  output logic                 misalignM,
  output logic                 buserrM,
  output logic                 bus_req,
  output logic                 bus_we,
  output logic [ADDR_SIZE-1:0] bus_addr,
  output logic [XLEN-1:0]      bus_wdata,
  output logic [3:0]           bus_wstrb,
  input  logic                 bus_gnt,
  input  logic                 bus_rvalid,
  input  logic [XLEN-1:0]      bus_rdata
);

  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP,
    DONE
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [ADDR_SIZE-1:0] r_addr;
  logic [1:0]          r_off;
  logic                r_we;
  logic [1:0]          r_size;
  logic                r_uns;
  logic [XLEN-1:0]     r_wdata;
  logic [3:0]          r_wstrb;
  logic [CW-1:0]       r_cnt;
  logic [XLEN-1:0]     r_rdata;
  logic                r_buserr;

  logic                w_byte;
  logic                w_half;
  logic                w_word;
  logic                w_mis;
  logic                w_tout;
  logic [XLEN-1:0]     w_wdata;
  logic [3:0]          w_wstrb;
  logic [7:0]          w_lbyte;
  logic [15:0]         w_lhalf;
  logic [XLEN-1:0]     w_ext;

  assign w_byte = (whbM == 2'b10);
  assign w_half = (whbM == 2'b01);
  assign w_word = !w_byte && !w_half;
  assign w_mis  = (w_half && addrM[0]) ||
                  (w_word && (addrM[1:0] != 2'b00));

  always_comb begin
    w_wdata = writedataM;
    w_wstrb = 4'b1111;
    unique case (1'b1)
      w_byte: begin
        w_wdata = {(XLEN/8){writedataM[7:0]}};
        w_wstrb = 4'b0001 << addrM[1:0];
      end
      w_half: begin
        w_wdata = {(XLEN/16){writedataM[15:0]}};
        w_wstrb = 4'b0011 << {addrM[1], 1'b0};
      end
      w_word: ;
    endcase
    if (!memwriteM) w_wstrb = 4'b0000;
  end

  // Lane select uses the latched byte offset, not the live address
  assign w_lbyte = bus_rdata[{r_off, 3'b000} +: 8];
  assign w_lhalf = bus_rdata[{r_off[1], 4'b0000} +: 16];

  always_comb begin
    w_ext = bus_rdata;
    case (r_size)
      2'b10:   w_ext = {{(XLEN-8){w_lbyte[7] & !r_uns}}, w_lbyte};
      2'b01:   w_ext = {{(XLEN-16){w_lhalf[15] & !r_uns}}, w_lhalf};
      default: w_ext = bus_rdata;
    endcase
  end

  always_comb begin
    w_next    = r_state;
    stallM    = 1'b0;
    misalignM = 1'b0;
    bus_req   = 1'b0;
    done_o    = 1'b0;
    w_tout    = 1'b0;
    case (r_state)
      IDLE: begin
        if (memreqM) begin
          if (w_mis) begin
            misalignM = 1'b1;
          end else begin
            stallM = 1'b1;
            w_next = REQ;
          end
        end
      end
      REQ: begin
        bus_req = 1'b1;
        stallM  = 1'b1;
        if (bus_gnt) w_next = r_we ? DONE : RESP;
      end
      RESP: begin
        stallM = 1'b1;
        if (bus_rvalid) begin
          w_next = DONE;
        end else if (r_cnt == CW'(TIMEOUT-1)) begin
          w_tout = 1'b1;
          w_next = DONE;
        end
      end
      DONE: begin
        done_o = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_addr   <= '0;
      r_off    <= '0;
      r_we     <= 1'b0;
      r_size   <= '0;
      r_uns    <= 1'b0;
      r_wdata  <= '0;
      r_wstrb  <= '0;
      r_cnt    <= '0;
      r_rdata  <= '0;
      r_buserr <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_buserr <= w_tout;
      case (r_state)
        IDLE: begin
          if (memreqM && !w_mis) begin
            r_addr  <= {addrM[ADDR_SIZE-1:2], 2'b00};
            r_off   <= addrM[1:0];
            r_we    <= memwriteM;
            r_size  <= whbM;
            r_uns   <= lunsignedM;
            r_wdata <= w_wdata;
            r_wstrb <= w_wstrb;
            r_rdata <= '0;
          end
        end
        REQ: begin
          if (bus_gnt) r_cnt <= '0;
        end
        RESP: begin
          r_cnt <= r_cnt + 1'b1;
          if (bus_rvalid) r_rdata <= w_ext;
          else if (w_tout) r_rdata <= '0;
        end
        default: ;
      endcase
    end
  end

  assign readdataM = (r_state == DONE) ? r_rdata : '0;
  assign buserrM   = r_buserr;
  assign bus_we    = r_we;
  assign bus_addr  = r_addr;
  assign bus_wdata = r_wdata;
  assign bus_wstrb = r_wstrb;

endmodule

// File: tb/tb_dmem_lsu.sv
// tb_dmem_lsu: directed bench for dmem_lsu stores, loads,
// misalign, grant stalls, timeout and reset abort.
module tb_dmem_lsu;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        memreqM;
  logic        memwriteM;
  logic [31:0] addrM;
  logic [31:0] writedataM;
  logic [1:0]  whbM;
  logic        lunsignedM;
  logic [31:0] readdataM;
  logic        done_o;
  logic        stallM;
  logic        misalignM;
  logic        buserrM;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_gnt;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;

  int tests = 0;
  int fails = 0;

  dmem_lsu #(
    .XLEN(32),
    .ADDR_SIZE(32),
    .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .memreqM(memreqM),
    .memwriteM(memwriteM),
    .addrM(addrM),
    .writedataM(writedataM),
    .whbM(whbM),
    .lunsignedM(lunsignedM),
    .readdataM(readdataM),
    .done_o(done_o),
    .stallM(stallM),
    .misalignM(misalignM),
    .buserrM(buserrM),
    .bus_req(bus_req),
    .bus_we(bus_we),
    .bus_addr(bus_addr),
    .bus_wdata(bus_wdata),
    .bus_wstrb(bus_wstrb),
    .bus_gnt(bus_gnt),
    .bus_rvalid(bus_rvalid),
    .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; memreqM = 0; memwriteM = 0;
    addrM = 0; writedataM = 0; whbM = 0;
    lunsignedM = 0; bus_gnt = 0; bus_rvalid = 0;
    bus_rdata = 0;
    tick(); tick();
    @(negedge clk); tests++;
    if ({bus_req, bus_we, bus_wstrb, stallM, done_o,
         misalignM, buserrM} !== 10'b0) begin
      fails++;
      $display("FAIL reset_ctl: got %b exp 0",
        {bus_req, bus_we, bus_wstrb, stallM, done_o,
         misalignM, buserrM});
    end
    tests++;
    if ({readdataM, bus_addr, bus_wdata} !== 96'h0) begin
      fails++;
      $display("FAIL reset_data: got %h exp 0",
        {readdataM, bus_addr, bus_wdata});
    end
    tick();
    reset = 1'b0;
    tick();
    @(negedge clk); tests++;
    if ({stallM, bus_req, done_o} !== 3'b000) begin
      fails++;
      $display("FAIL post_reset: got %b exp 000",
        {stallM, bus_req, done_o});
    end
    tick();
  endtask

  task automatic test_sw();
    memreqM = 1; memwriteM = 1; addrM = 32'h100;
    writedataM = 32'hDEADBEEF; whbM = 2'b00;
    bus_gnt = 0;
    @(negedge clk); tests++;
    if ({stallM, bus_req, done_o} !== 3'b100) begin
      fails++;
      $display("FAIL sw_idle: got %b exp 100",
        {stallM, bus_req, done_o});
    end
    tick();
    bus_gnt = 1;
    @(negedge clk); tests++;
    if ({stallM, bus_req, bus_we, bus_wstrb, bus_addr,
         bus_wdata} !== {3'b111, 4'hF, 32'h100,
                         32'hDEADBEEF}) begin
      fails++;
      $display("FAIL sw_req: got %b %h %h exp 1111111 100 deadbeef",
        {stallM, bus_req, bus_we, bus_wstrb},
        bus_addr, bus_wdata);
    end
    tick();
    bus_gnt = 0;
    @(negedge clk); tests++;
    if ({stallM, done_o, bus_req} !== 3'b010) begin
      fails++;
      $display("FAIL sw_done: got %b exp 010",
        {stallM, done_o, bus_req});
    end
    tick();
    memreqM = 0;
    @(negedge clk); tests++;
    if ({done_o, bus_req, stallM} !== 3'b000) begin
      fails++;
      $display("FAIL sw_idle2: got %b exp 000",
        {done_o, bus_req, stallM});
    end
    tick();
  endtask

  task automatic test_sb();
    memreqM = 1; memwriteM = 1; addrM = 32'h203;
    writedataM = 32'h000000A5; whbM = 2'b10;
    bus_gnt = 0;
    tick();
    bus_gnt = 1;
    @(negedge clk); tests++;
    if ({bus_req, bus_we, bus_wstrb, bus_addr,
         bus_wdata} !== {2'b11, 4'b1000, 32'h200,
                         32'hA5A5A5A5}) begin
      fails++;
      $display("FAIL sb_req: got %b %h %h exp 111000 200 a5a5a5a5",
        {bus_req, bus_we, bus_wstrb}, bus_addr, bus_wdata);
    end
    tick();
    bus_gnt = 0;
    @(negedge clk); tests++;
    if (done_o !== 1'b1) begin
      fails++;
      $display("FAIL sb_done: got %b exp 1", done_o);
    end
    tick();
    memreqM = 0;
    tick();
  endtask

  task automatic test_lh(input logic uns,
                         input logic [31:0] exp);
    memreqM = 1; memwriteM = 0; addrM = 32'h102;
    whbM = 2'b01; lunsignedM = uns; bus_gnt = 0;
    tick();
    bus_gnt = 1;
    @(negedge clk); tests++;
    if ({bus_req, bus_we, bus_wstrb, bus_addr} !==
        {2'b10, 4'b0000, 32'h100}) begin
      fails++;
      $display("FAIL lh_req: got %b %h exp 100000 100",
        {bus_req, bus_we, bus_wstrb}, bus_addr);
    end
    tick();
    bus_gnt = 0; bus_rvalid = 1; bus_rdata = 32'h80011234;
    @(negedge clk); tests++;
    if ({stallM, bus_req, done_o} !== 3'b100) begin
      fails++;
      $display("FAIL lh_resp: got %b exp 100",
        {stallM, bus_req, done_o});
    end
    tick();
    bus_rvalid = 0; bus_rdata = 32'hFFFFFFFF;
    @(negedge clk); tests++;
    if ({done_o, stallM, readdataM} !== {2'b10, exp}) begin
      fails++;
      $display("FAIL lh_done u=%0d: got %b %h exp 10 %h",
        uns, {done_o, stallM}, readdataM, exp);
    end
    tick();
    memreqM = 0;
    tick();
  endtask

  task automatic test_misalign();
    memreqM = 1; memwriteM = 0; addrM = 32'h106;
    whbM = 2'b00; lunsignedM = 0;
    @(negedge clk); tests++;
    if ({misalignM, stallM, bus_req, readdataM} !==
        {3'b100, 32'h0}) begin
      fails++;
      $display("FAIL mis_lw: got %b %h exp 100 0",
        {misalignM, stallM, bus_req}, readdataM);
    end
    tick();
    memreqM = 0;
    @(negedge clk); tests++;
    if ({misalignM, stallM, bus_req, done_o} !== 4'b0) begin
      fails++;
      $display("FAIL mis_after: got %b exp 0000",
        {misalignM, stallM, bus_req, done_o});
    end
    memreqM = 1; addrM = 32'h101; whbM = 2'b01;
    @(negedge clk); tests++;
    if ({misalignM, stallM} !== 2'b10) begin
      fails++;
      $display("FAIL mis_lh: got %b exp 10",
        {misalignM, stallM});
    end
    tick();
    memreqM = 0;
    tick();
  endtask

  task automatic test_gnt_wait();
    memreqM = 1; memwriteM = 0; addrM = 32'h301;
    whbM = 2'b10; lunsignedM = 0; bus_gnt = 0;
    tick();
    for (int k = 0; k < 6; k++) begin
      if (k == 1) begin memreqM = 0; addrM = 32'hFFF; end
      if (k == 2) begin bus_rvalid = 1; bus_rdata = 32'hFF; end
      if (k == 3) bus_rvalid = 0;
      if (k == 5) bus_gnt = 1;
      @(negedge clk); tests++;
      if ({bus_req, stallM, bus_we, bus_wstrb, bus_addr} !==
          {3'b110, 4'b0000, 32'h300}) begin
        fails++;
        $display("FAIL gw_req%0d: got %b %h exp 1100000 300",
          k, {bus_req, stallM, bus_we, bus_wstrb}, bus_addr);
      end
      tick();
    end
    bus_gnt = 0; bus_rvalid = 1; bus_rdata = 32'h00007F00;
    @(negedge clk); tests++;
    if ({stallM, bus_req} !== 2'b10) begin
      fails++;
      $display("FAIL gw_resp: got %b exp 10",
        {stallM, bus_req});
    end
    tick();
    bus_rvalid = 0;
    @(negedge clk); tests++;
    if ({done_o, readdataM} !== {1'b1, 32'h7F}) begin
      fails++;
      $display("FAIL gw_done: got %b %h exp 1 0000007f",
        done_o, readdataM);
    end
    tick();
    tick();
  endtask

  task automatic test_back_to_back();
    memreqM = 1; memwriteM = 1; addrM = 32'h502;
    writedataM = 32'h1234ABCD; whbM = 2'b01;
    bus_gnt = 0;
    tick();
    bus_gnt = 1;
    @(negedge clk); tests++;
    if ({bus_wstrb, bus_addr, bus_wdata} !==
        {4'b1100, 32'h500, 32'hABCDABCD}) begin
      fails++;
      $display("FAIL b2b_sh: got %b %h %h exp 1100 500 abcdabcd",
        bus_wstrb, bus_addr, bus_wdata);
    end
    tick();
    bus_gnt = 0;
    tick();
    memwriteM = 0; addrM = 32'h203; whbM = 2'b10;
    lunsignedM = 1;
    @(negedge clk); tests++;
    if ({stallM, done_o} !== 2'b10) begin
      fails++;
      $display("FAIL b2b_start: got %b exp 10",
        {stallM, done_o});
    end
    tick();
    bus_gnt = 1;
    @(negedge clk); tests++;
    if ({bus_req, bus_wstrb, bus_addr} !==
        {1'b1, 4'b0000, 32'h200}) begin
      fails++;
      $display("FAIL b2b_lreq: got %b %h exp 10000 200",
        {bus_req, bus_wstrb}, bus_addr);
    end
    tick();
    bus_gnt = 0; bus_rvalid = 1; bus_rdata = 32'h80FF0000;
    tick();
    bus_rvalid = 0;
    @(negedge clk); tests++;
    if ({done_o, readdataM} !== {1'b1, 32'h80}) begin
      fails++;
      $display("FAIL b2b_lbu: got %b %h exp 1 00000080",
        done_o, readdataM);
    end
    tick();
    memreqM = 0;
    tick();
  endtask

  task automatic test_timeout();
    memreqM = 1; memwriteM = 0; addrM = 32'h400;
    whbM = 2'b00; lunsignedM = 0; bus_gnt = 0;
    bus_rdata = 32'h5555AAAA;
    tick();
    bus_gnt = 1;
    tick();
    bus_gnt = 0;
    for (int k = 0; k < TO; k++) begin
      @(negedge clk); tests++;
      if ({stallM, done_o, buserrM, bus_req} !== 4'b1000) begin
        fails++;
        $display("FAIL to_resp%0d: got %b exp 1000",
          k, {stallM, done_o, buserrM, bus_req});
      end
      tick();
    end
    @(negedge clk); tests++;
    if ({done_o, buserrM, stallM, readdataM} !==
        {3'b110, 32'h0}) begin
      fails++;
      $display("FAIL to_done: got %b %h exp 110 0",
        {done_o, buserrM, stallM}, readdataM);
    end
    tick();
    memreqM = 0;
    @(negedge clk); tests++;
    if ({buserrM, done_o} !== 2'b00) begin
      fails++;
      $display("FAIL to_pulse: got %b exp 00",
        {buserrM, done_o});
    end
    tick();
  endtask

  task automatic test_reset_abort();
    memreqM = 1; memwriteM = 0; addrM = 32'h600;
    whbM = 2'b00; bus_gnt = 0;
    tick();
    bus_gnt = 1;
    tick();
    bus_gnt = 0;
    tick(); tick(); tick();
    reset = 1; memreqM = 0;
    tick();
    reset = 0; bus_rvalid = 1; bus_rdata = 32'h12345678;
    @(negedge clk); tests++;
    if ({done_o, stallM, bus_req, readdataM} !==
        {3'b000, 32'h0}) begin
      fails++;
      $display("FAIL ra_late: got %b %h exp 000 0",
        {done_o, stallM, bus_req}, readdataM);
    end
    tick();
    bus_rvalid = 0;
    @(negedge clk); tests++;
    if ({done_o, buserrM, readdataM} !== {2'b00, 32'h0}) begin
      fails++;
      $display("FAIL ra_after: got %b %h exp 00 0",
        {done_o, buserrM}, readdataM);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_sw();
    test_sb();
    test_lh(1'b0, 32'hFFFF8001);
    test_lh(1'b1, 32'h00008001);
    test_misalign();
    test_gnt_wait();
    test_back_to_back();
    test_timeout();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
